msrv32_integer_file: RTL and testbench

Architectural integer register file, x0–x31, sitting directly downstream of the writeback mux select unit. It captures the selected writeback value into the addressed destination register and serves the two source-operand read ports to the decode/operand stage. Reads are combinational with write-through bypass, so a value written in one cycle is visible to a read of the same register in that same cycle. x0 is hard-wired to zero.

---
 rtl/msrv32_integer_file_if.sv | 27 ++
 rtl/msrv32_integer_file.sv | 53 +++++
 tb/tb_msrv32_integer_file.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_integer_file_if.sv
// Read/write port bundle of the integer register file: writeback-stage
// write controls in, two combinational source-operand read ports out.
interface msrv32_integer_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_1_addr_in;
  logic [ADDR_W-1:0] rs_2_addr_in;
  logic [ADDR_W-1:0] rd_addr_reg_in;
  logic              wr_en_int_in;
  logic              flush_in;
  logic [DATA_W-1:0] wb_mux_out_in;
  logic [DATA_W-1:0] rs_1_out;
  logic [DATA_W-1:0] rs_2_out;

  modport master (
    output rs_1_addr_in, rs_2_addr_in, rd_addr_reg_in,
    output wr_en_int_in, flush_in, wb_mux_out_in,
    input  rs_1_out, rs_2_out
  );

  modport slave (
    input  rs_1_addr_in, rs_2_addr_in, rd_addr_reg_in,
    input  wr_en_int_in, flush_in, wb_mux_out_in,
    output rs_1_out, rs_2_out
  );
endinterface

// File: rtl/msrv32_integer_file.sv
// Architectural integer register file x0..x31 with write-through bypass;
// x0 is not stored and always reads zero.
module msrv32_integer_file #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_n_in,
  msrv32_integer_file_if.slave  rf
);

  logic [DATA_W-1:0] regs [1:NREGS-1];
  logic              wr_eff;
  logic              byp_en;

  assign wr_eff = rf.wr_en_int_in & ~rf.flush_in & (rf.rd_addr_reg_in != '0);
  // While reset is held the write path is dead, so reads show storage only.
  assign byp_en = wr_eff & ms_riscv32_mp_rst_n_in;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_eff) begin
      regs[rf.rd_addr_reg_in] <= rf.wb_mux_out_in;
    end
  end

  always_comb begin
    rf.rs_1_out = '0;
    if (rf.rs_1_addr_in != '0) begin
      if (byp_en && (rf.rd_addr_reg_in == rf.rs_1_addr_in)) begin
        rf.rs_1_out = rf.wb_mux_out_in;
      end else begin
        rf.rs_1_out = regs[rf.rs_1_addr_in];
      end
    end
  end

  always_comb begin
    rf.rs_2_out = '0;
    if (rf.rs_2_addr_in != '0) begin
      if (byp_en && (rf.rd_addr_reg_in == rf.rs_2_addr_in)) begin
        rf.rs_2_out = rf.wb_mux_out_in;
      end else begin
        rf.rs_2_out = regs[rf.rs_2_addr_in];
      end
    end
  end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Self-checking bench for msrv32_integer_file: directed scenarios plus a
// randomized run against an array model of the architectural registers.
module tb_msrv32_integer_file;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;
  logic [31:0] model [32];

  msrv32_integer_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .rf                     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value from the architectural rules and current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rst_n && bus.wr_en_int_in && !bus.flush_in && bus.rd_addr_reg_in == a)
      return bus.wb_mux_out_in;
    return model[a];
  endfunction

  // Advance one rising edge, applying the same rules to the model, and
  // return on the falling edge so inputs change away from the active edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (bus.wr_en_int_in && !bus.flush_in && bus.rd_addr_reg_in != 5'd0) begin
      model[bus.rd_addr_reg_in] = bus.wb_mux_out_in;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wr_en_int_in  = 1'b0;
    bus.flush_in      = 1'b0;
    bus.rd_addr_reg_in = 5'd0;
    bus.wb_mux_out_in = 32'h0;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] d);
    bus.wr_en_int_in   = 1'b1;
    bus.flush_in       = 1'b0;
    bus.rd_addr_reg_in = rd;
    bus.wb_mux_out_in  = d;
    tick();
    idle();
  endtask

  task automatic rd_ports(input logic [4:0] a1, input logic [4:0] a2);
    bus.rs_1_addr_in = a1;
    bus.rs_2_addr_in = a2;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
    rd_ports(5'd1, 5'd31);
    vectors++;
    if (bus.rs_1_out !== 32'h0 || bus.rs_2_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_init rs1=%h rs2=%h required 0/0", bus.rs_1_out, bus.rs_2_out);
    end
    wr(5'd5, 32'hDEADBEEF);
    rd_ports(5'd5, 5'd31);
    vectors++;
    if (bus.rs_1_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_prewrite rs1=%h required deadbeef", bus.rs_1_out);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rd_ports(5'd5, 5'd31);
    vectors++;
    if (bus.rs_1_out !== 32'h0 || bus.rs_2_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_clear rs1=%h rs2=%h required 0/0", bus.rs_1_out, bus.rs_2_out);
    end
  endtask

  task automatic test_basic();
    wr(5'd1, 32'hA5A5A5A5);
    wr(5'd2, 32'h12345678);
    rd_ports(5'd1, 5'd2);
    vectors++;
    if (bus.rs_1_out !== 32'hA5A5A5A5 || bus.rs_2_out !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_rw rs1=%h rs2=%h required a5a5a5a5/12345678", bus.rs_1_out, bus.rs_2_out);
    end
  endtask

  task automatic test_x0();
    bus.wr_en_int_in   = 1'b1;
    bus.rd_addr_reg_in = 5'd0;
    bus.wb_mux_out_in  = 32'hFFFFFFFF;
    rd_ports(5'd0, 5'd0);
    vectors++;
    if (bus.rs_1_out !== 32'h0 || bus.rs_2_out !== 32'h0) begin
      errors++;
      $display("FAIL x0_same_cycle rs1=%h rs2=%h required 0/0", bus.rs_1_out, bus.rs_2_out);
    end
    tick();
    idle();
    rd_ports(5'd0, 5'd1);
    vectors++;
    if (bus.rs_1_out !== 32'h0 || bus.rs_2_out !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL x0_next_cycle rs1=%h rs2=%h required 0/a5a5a5a5", bus.rs_1_out, bus.rs_2_out);
    end
  endtask

  task automatic test_bypass();
    wr(5'd7, 32'h1);
    bus.wr_en_int_in   = 1'b1;
    bus.rd_addr_reg_in = 5'd7;
    bus.wb_mux_out_in  = 32'h98765432;
    rd_ports(5'd7, 5'd7);
    vectors++;
    if (bus.rs_1_out !== 32'h98765432 || bus.rs_2_out !== 32'h98765432) begin
      errors++;
      $display("FAIL bypass_dual rs1=%h rs2=%h required 98765432", bus.rs_1_out, bus.rs_2_out);
    end
    tick();
    idle();
    rd_ports(5'd7, 5'd7);
    vectors++;
    if (bus.rs_1_out !== 32'h98765432 || bus.rs_2_out !== 32'h98765432) begin
      errors++;
      $display("FAIL bypass_stored rs1=%h rs2=%h required 98765432", bus.rs_1_out, bus.rs_2_out);
    end
    // Back-to-back: second write wins and is bypassed in its own cycle.
    wr(5'd9, 32'h11111111);
    bus.wr_en_int_in   = 1'b1;
    bus.rd_addr_reg_in = 5'd9;
    bus.wb_mux_out_in  = 32'h22222222;
    rd_ports(5'd9, 5'd7);
    vectors++;
    if (bus.rs_1_out !== 32'h22222222 || bus.rs_2_out !== 32'h98765432) begin
      errors++;
      $display("FAIL back_to_back rs1=%h rs2=%h required 22222222/98765432", bus.rs_1_out, bus.rs_2_out);
    end
    tick();
    idle();
  endtask

  task automatic test_flush();
    wr(5'd3, 32'h2468ACE0);
    bus.wr_en_int_in   = 1'b1;
    bus.flush_in       = 1'b1;
    bus.rd_addr_reg_in = 5'd3;
    bus.wb_mux_out_in  = 32'h13579BDF;
    rd_ports(5'd3, 5'd3);
    vectors++;
    if (bus.rs_1_out !== 32'h2468ACE0) begin
      errors++;
      $display("FAIL flush_same_cycle rs1=%h required 2468ace0", bus.rs_1_out);
    end
    tick();
    idle();
    rd_ports(5'd3, 5'd0);
    vectors++;
    if (bus.rs_1_out !== 32'h2468ACE0) begin
      errors++;
      $display("FAIL flush_next_cycle rs1=%h required 2468ace0", bus.rs_1_out);
    end
  endtask

  task automatic test_write_during_reset();
    wr(5'd4, 32'h55AA55AA);
    rst_n = 1'b0;
    bus.wr_en_int_in   = 1'b1;
    bus.rd_addr_reg_in = 5'd4;
    bus.wb_mux_out_in  = 32'hBCDEF012;
    rd_ports(5'd4, 5'd0);
    vectors++;
    if (bus.rs_1_out !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL reset_no_bypass rs1=%h required 55aa55aa", bus.rs_1_out);
    end
    tick();
    rst_n = 1'b1;
    idle();
    rd_ports(5'd4, 5'd4);
    vectors++;
    if (bus.rs_1_out !== 32'h0 || bus.rs_2_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_dropped rs1=%h rs2=%h required 0/0", bus.rs_1_out, bus.rs_2_out);
    end
    wr(5'd4, 32'hBCDEF012);
    rd_ports(5'd4, 5'd0);
    vectors++;
    if (bus.rs_1_out !== 32'hBCDEF012) begin
      errors++;
      $display("FAIL first_write_after_reset rs1=%h required bcdef012", bus.rs_1_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      bus.wr_en_int_in   = ($urandom_range(0, 3) != 0);
      bus.flush_in       = ($urandom_range(0, 5) == 0);
      bus.rd_addr_reg_in = 5'($urandom_range(0, 7));
      bus.wb_mux_out_in  = $urandom;
      if ($urandom_range(0, 2) == 0) bus.rs_1_addr_in = bus.rd_addr_reg_in;
      else bus.rs_1_addr_in = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) bus.rs_2_addr_in = bus.rd_addr_reg_in;
      else bus.rs_2_addr_in = 5'($urandom_range(0, 31));
      #1;
      e1 = exp_read(bus.rs_1_addr_in);
      e2 = exp_read(bus.rs_2_addr_in);
      vectors++;
      if (bus.rs_1_out !== e1 || bus.rs_2_out !== e2) begin
        errors++;
        $display("FAIL random_%0d a1=%0d a2=%0d rs1=%h rs2=%h required %h/%h",
                 n, bus.rs_1_addr_in, bus.rs_2_addr_in, bus.rs_1_out, bus.rs_2_out, e1, e2);
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    bus.rs_1_addr_in = 5'd0;
    bus.rs_2_addr_in = 5'd0;
    idle();
    @(negedge clk);
    test_reset();
    test_basic();
    test_x0();
    test_bypass();
    test_flush();
    test_write_during_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
